// File: rtl/bp_pkg.sv
// bp_pkg: shared types, default depth and squash helper for the branch resolve queue
package bp_pkg;
   localparam int BRQ_DEPTH = 8;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        pred;
      logic        resolved;
      logic        taken;
   } brq_entry_t;
   // true when tag is strictly younger than ref_tag, ages measured from head modulo depth
   function automatic logic is_younger(input logic [31:0] tag, input logic [31:0] ref_tag,
                                       input logic [31:0] head, input logic [31:0] depth);
      return ((tag - head) & (depth - 1)) > ((ref_tag - head) & (depth - 1));
   endfunction
endpackage

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order branch tracking queue with out-of-order resolve, mispredict squash and in-order predictor update
// Ports: alloc_* from fetch (tag returned on alloc_tag), resolve_* from execute,
//        mispredict/redirect_pc registered redirect pulse, upd_* to predictor update port,
//        perf_branches/perf_mispredicts wrapping event counters.
module branch_resolve_queue
   import bp_pkg::*;
#(
   parameter int DEPTH = BRQ_DEPTH,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_valid,
   input  logic [31:0]      alloc_pc,
   input  logic             alloc_pred,
   output logic             alloc_ready,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             resolve_valid,
   input  logic [TAG_W-1:0] resolve_tag,
   input  logic             resolve_taken,
   input  logic [31:0]      resolve_target,
   output logic             mispredict,
   output logic [31:0]      redirect_pc,
   output logic             upd_valid,
   output logic [31:0]      upd_pc,
   output logic             upd_taken,
   output logic [31:0]      perf_branches,
   output logic [31:0]      perf_mispredicts
);
   localparam int CW = TAG_W + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   brq_entry_t ent_q [DEPTH];
   brq_entry_t ent_d [DEPTH];
   brq_entry_t res_e, hd_e;
   logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, span;
   logic [CW-1:0] count_q, count_d;
   logic res_ok, mis, retire, alloc_do;
   logic mispredict_q, upd_valid_q, upd_taken_q;
   logic [31:0] redirect_pc_q, upd_pc_q, perf_br_q, perf_mis_q;
   assign alloc_ready = count_q != FULL;
   assign alloc_tag = tail_q;
   assign res_e = ent_q[resolve_tag];
   assign hd_e = ent_q[head_q];
   assign res_ok = resolve_valid && res_e.valid && !res_e.resolved;
   assign mis = res_ok && (resolve_taken != res_e.pred);
   // retire looks only at registered state, so a head resolved this cycle retires next edge
   assign retire = hd_e.valid && hd_e.resolved;
   // squash wins over a same-cycle allocation
   assign alloc_do = alloc_valid && alloc_ready && !mis;
   assign span = resolve_tag - head_q;
   assign head_d = retire ? head_q + 1'b1 : head_q;
   assign tail_d = mis ? resolve_tag + 1'b1 : alloc_do ? tail_q + 1'b1 : tail_q;
   assign count_d = mis ? {1'b0, span} + CW'(1) - CW'(retire)
                        : count_q + CW'(alloc_do) - CW'(retire);
   always_comb begin
      ent_d = ent_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (retire && TAG_W'(i) == head_q) ent_d[i].valid = 1'b0;
         if (res_ok && TAG_W'(i) == resolve_tag) begin
            ent_d[i].resolved = 1'b1;
            ent_d[i].taken = resolve_taken;
         end
         if (mis && is_younger(32'(i), 32'(resolve_tag), 32'(head_q), 32'(DEPTH))) ent_d[i].valid = 1'b0;
         if (alloc_do && TAG_W'(i) == tail_q)
            ent_d[i] = '{valid: 1'b1, pc: alloc_pc, pred: alloc_pred, resolved: 1'b0, taken: 1'b0};
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         head_q <= '0;
         tail_q <= '0;
         count_q <= '0;
         mispredict_q <= 1'b0;
         redirect_pc_q <= '0;
         upd_valid_q <= 1'b0;
         upd_pc_q <= '0;
         upd_taken_q <= 1'b0;
         perf_br_q <= '0;
         perf_mis_q <= '0;
      end else begin
         ent_q <= ent_d;
         head_q <= head_d;
         tail_q <= tail_d;
         count_q <= count_d;
         mispredict_q <= mis;
         redirect_pc_q <= mis ? (resolve_taken ? resolve_target : res_e.pc + 32'd4) : redirect_pc_q;
         upd_valid_q <= retire;
         upd_pc_q <= retire ? hd_e.pc : upd_pc_q;
         upd_taken_q <= retire ? hd_e.taken : upd_taken_q;
         perf_br_q <= perf_br_q + 32'(retire);
         perf_mis_q <= perf_mis_q + 32'(mis);
      end
   end
   assign mispredict = mispredict_q;
   assign redirect_pc = redirect_pc_q;
   assign upd_valid = upd_valid_q;
   assign upd_pc = upd_pc_q;
   assign upd_taken = upd_taken_q;
   assign perf_branches = perf_br_q;
   assign perf_mispredicts = perf_mis_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: scoreboard bench for branch_resolve_queue with directed vectors
module tb_branch_resolve_queue;
   logic clk = 1'b0;
   logic rst;
   logic alloc_valid, alloc_pred, alloc_ready;
   logic [31:0] alloc_pc;
   logic [2:0] alloc_tag, resolve_tag;
   logic resolve_valid, resolve_taken;
   logic [31:0] resolve_target;
   logic mispredict, upd_valid, upd_taken;
   logic [31:0] redirect_pc, upd_pc, perf_branches, perf_mispredicts;
   typedef struct {
      logic [31:0] pc;
      logic        t;
   } upd_t;
   upd_t exp_upd[$];
   logic [31:0] exp_mis[$];
   int n_cmp = 0;
   int n_bad = 0;
   branch_resolve_queue dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
      .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
      .resolve_taken(resolve_taken), .resolve_target(resolve_target),
      .mispredict(mispredict), .redirect_pc(redirect_pc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic alloc(input logic [31:0] pc, input logic p);
      alloc_valid = 1'b1;
      alloc_pc = pc;
      alloc_pred = p;
      tick();
      alloc_valid = 1'b0;
   endtask
   task automatic resolve(input logic [2:0] tag, input logic t, input logic [31:0] tgt);
      resolve_valid = 1'b1;
      resolve_tag = tag;
      resolve_taken = t;
      resolve_target = tgt;
      tick();
      resolve_valid = 1'b0;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask
   // monitor: every presented update or redirect must match the oldest expectation
   initial begin
      upd_t u;
      forever begin
         @(negedge clk);
         if (upd_valid) begin
            if (exp_upd.size() == 0) check("unexpected_upd", upd_pc, 32'hdead_beef);
            else begin
               u = exp_upd.pop_front();
               check("upd_pc", upd_pc, u.pc);
               check("upd_taken", 32'(upd_taken), 32'(u.t));
            end
         end
         if (mispredict) begin
            if (exp_mis.size() == 0) check("unexpected_mispredict", redirect_pc, 32'hdead_beef);
            else check("redirect_pc", redirect_pc, exp_mis.pop_front());
         end
      end
   end
   initial begin
      rst = 1'b1;
      alloc_valid = 1'b0; alloc_pc = '0; alloc_pred = 1'b0;
      resolve_valid = 1'b0; resolve_tag = '0; resolve_taken = 1'b0; resolve_target = '0;
      tick(); tick();
      rst = 1'b0;
      check("rst_alloc_ready", 32'(alloc_ready), 1);
      check("rst_alloc_tag", 32'(alloc_tag), 0);
      check("rst_mispredict", 32'(mispredict), 0);
      check("rst_redirect_pc", redirect_pc, 0);
      check("rst_upd_valid", 32'(upd_valid), 0);
      check("rst_upd_pc", upd_pc, 0);
      check("rst_upd_taken", 32'(upd_taken), 0);
      check("rst_perf_br", perf_branches, 0);
      check("rst_perf_mis", perf_mispredicts, 0);
      // reset with pending retire: no update may appear
      alloc(32'h10, 0); alloc(32'h14, 0); alloc(32'h18, 0);
      check("mid_tag", 32'(alloc_tag), 3);
      resolve(0, 0, 0);
      do_reset();
      check("mid_count", 32'(dut.count_q), 0);
      check("mid_ready", 32'(alloc_ready), 1);
      check("mid_tag0", 32'(alloc_tag), 0);
      tick(); tick(); tick();
      check("mid_perf_br", perf_branches, 0);
      // in-order retire with out-of-order resolve
      alloc(32'h100, 0); alloc(32'h104, 0); alloc(32'h108, 0);
      exp_upd.push_back('{32'h100, 1'b0});
      exp_upd.push_back('{32'h104, 1'b0});
      exp_upd.push_back('{32'h108, 1'b0});
      resolve(2, 0, 0); resolve(0, 0, 0); resolve(1, 0, 0);
      tick(); tick(); tick(); tick();
      check("ino_perf_br", perf_branches, 3);
      check("ino_perf_mis", perf_mispredicts, 0);
      check("ino_count", 32'(dut.count_q), 0);
      // mispredict squash
      do_reset();
      for (int i = 0; i < 4; i++) alloc(32'h200 + 32'(4 * i), 0);
      exp_mis.push_back(32'h400);
      resolve(1, 1, 32'h400);
      check("sq_count", 32'(dut.count_q), 2);
      check("sq_tag", 32'(alloc_tag), 2);
      check("sq_ready", 32'(alloc_ready), 1);
      resolve(3, 1, 32'h999);
      check("sq_perf_mis", perf_mispredicts, 1);
      exp_upd.push_back('{32'h200, 1'b0});
      exp_upd.push_back('{32'h204, 1'b1});
      resolve(0, 0, 0);
      tick(); tick(); tick();
      check("sq_count_end", 32'(dut.count_q), 0);
      check("sq_perf_br", perf_branches, 2);
      // not-taken mispredict with pc+4 wrap
      alloc(32'hFFFF_FFFC, 1);
      exp_mis.push_back(32'h0);
      exp_upd.push_back('{32'hFFFF_FFFC, 1'b0});
      resolve(2, 0, 32'h1234);
      tick(); tick(); tick();
      check("nt_perf_mis", perf_mispredicts, 2);
      check("nt_perf_br", perf_branches, 3);
      check("nt_tag", 32'(alloc_tag), 3);
      // full and wrap
      do_reset();
      for (int i = 0; i < 8; i++) alloc(32'h300 + 32'(4 * i), 0);
      check("full_ready", 32'(alloc_ready), 0);
      check("full_count", 32'(dut.count_q), 8);
      check("full_tag", 32'(alloc_tag), 0);
      exp_upd.push_back('{32'h300, 1'b0});
      resolve(0, 0, 0);
      alloc_valid = 1'b1; alloc_pc = 32'h5AA; alloc_pred = 1'b0;
      tick();
      alloc_valid = 1'b0;
      check("blk_count", 32'(dut.count_q), 7);
      check("blk_tag", 32'(alloc_tag), 0);
      check("blk_ready", 32'(alloc_ready), 1);
      alloc(32'h500, 0);
      check("wrap_count", 32'(dut.count_q), 8);
      check("wrap_tag", 32'(alloc_tag), 1);
      check("wrap_ready", 32'(alloc_ready), 0);
      // retire and squash in the same cycle
      resolve(1, 0, 0);
      exp_upd.push_back('{32'h304, 1'b0});
      exp_mis.push_back(32'h600);
      resolve(3, 1, 32'h600);
      check("rs_count", 32'(dut.count_q), 2);
      check("rs_tag", 32'(alloc_tag), 4);
      // squash and allocate in the same cycle: allocation dropped
      exp_mis.push_back(32'h700);
      exp_upd.push_back('{32'h308, 1'b1});
      alloc_valid = 1'b1; alloc_pc = 32'h800; alloc_pred = 1'b0;
      resolve(2, 1, 32'h700);
      alloc_valid = 1'b0;
      check("sa_count", 32'(dut.count_q), 1);
      check("sa_tag", 32'(alloc_tag), 3);
      tick(); tick(); tick();
      check("end_count", 32'(dut.count_q), 0);
      check("end_perf_br", perf_branches, 3);
      check("end_perf_mis", perf_mispredicts, 2);
      check("end_upd_left", 32'(exp_upd.size()), 0);
      check("end_mis_left", 32'(exp_mis.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
